// File: rtl/calc_pkg.sv
// Shared definitions for the signed calculator datapath (operand width, FSM states).
package calc_pkg;

    localparam int unsigned CALC_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_6b_if.sv
// Request/result bus between the calculator sequencer and the serial adder.
interface serial_adder_6b_if
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    // Requester side: drives operands and start, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  start, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_6b_full_adder.sv
// Single full-adder cell in gate-level form, shared style with the subtractor cells.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term reused by both sum and carry.
    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_adder_6b.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB-first, W clocks per result.
module serial_adder_6b
    import calc_pkg::*;
#(
    parameter int unsigned W = CALC_W
)(
    input  logic                clk,
    input  logic                rst,
    serial_adder_6b_if.slave    bus
);

    localparam int unsigned     CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     sa_q, sa_d;
    logic [W-1:0]     sb_q, sb_d;
    logic [W-1:0]     ps_q, ps_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic             accept_c;
    logic             last_c;

    // The one adder cell, fed from the LSBs of the operand shifters and the carry flop.
    full_adder u_fa (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // A new request is taken only when not mid-operation; start during RUN is dropped.
    assign accept_c = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_c   = (state_q == RUN) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; sum/cout/ovf only move on the completing edge.
    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        ps_d   = ps_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        if (accept_c) begin
            sa_d  = bus.a;
            sb_d  = bus.b;
            ps_d  = '0;
            cnt_d = '0;
            c_d   = 1'b0;
        end else if (state_q == RUN) begin
            sa_d = {1'b0, sa_q[W-1:1]};
            sb_d = {1'b0, sb_q[W-1:1]};
            ps_d = {fa_s, ps_q[W-1:1]};
            c_d  = fa_co;
            if (last_c) begin
                // c_q is the carry into the MSB on this edge.
                sum_d  = {fa_s, ps_q[W-1:1]};
                cout_d = fa_co;
                ovf_d  = c_q ^ fa_co;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sa_q   <= '0;
            sb_q   <= '0;
            ps_q   <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            ps_q   <= ps_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_6b.sv
// Self-checking bench for serial_adder_6b against an arithmetic reference model.
module tb_serial_adder_6b;
    import calc_pkg::*;

    localparam int unsigned W = CALC_W;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder_6b_if #(.W(W)) bus ();

    serial_adder_6b #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain integer addition, unsigned for carry, signed range for overflow.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        int tot;
        int sv;
        tot = int'(x) + int'(y);
        sv  = int'($signed(x)) + int'($signed(y));
        s   = W'(tot);
        co  = (tot >= (1 << W));
        ov  = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    endfunction

    // One operation; optional stray start with other operands during RUN.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        logic [W-1:0] es, old_sum;
        logic         ec, eo, old_c, old_o;
        int           busy_cnt, lat;
        bit           seen;
        model(x, y, es, ec, eo);
        old_sum = bus.sum; old_c = bus.cout; old_o = bus.ovf;
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cnt = 0; seen = 0; lat = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (poke && k == 1) begin
                bus.start = 1'b1; bus.a = ~x; bus.b = x ^ y;
            end
            if (poke && k == 2) bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                seen = 1; lat = k;
            end else begin
                checks++;
                if ({bus.sum, bus.cout, bus.ovf} !== {old_sum, old_c, old_o}) begin
                    errors++;
                    $display("FAIL hold k=%0d got sum=%b c=%b o=%b want sum=%b c=%b o=%b",
                             k, bus.sum, bus.cout, bus.ovf, old_sum, old_c, old_o);
                end
            end
        end
        checks++;
        if (lat !== int'(W)) begin
            errors++; $display("FAIL latency %0d+%0d got %0d want %0d", x, y, lat, W);
        end
        checks++;
        if (busy_cnt !== int'(W)) begin
            errors++; $display("FAIL busy_cycles got %0d want %0d", busy_cnt, W);
        end
        checks++;
        if (bus.sum !== es) begin
            errors++; $display("FAIL sum %b+%b got %b want %b", x, y, bus.sum, es);
        end
        checks++;
        if (bus.cout !== ec) begin
            errors++; $display("FAIL cout %b+%b got %b want %b", x, y, bus.cout, ec);
        end
        checks++;
        if (bus.ovf !== eo) begin
            errors++; $display("FAIL ovf %b+%b got %b want %b", x, y, bus.ovf, eo);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL done_pulse got %b want 0", bus.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%b c=%b o=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(6'b000101, 6'b000111, 1'b0);
        do_op(6'b011111, 6'b000001, 1'b0);
        do_op(6'b111111, 6'b111111, 1'b0);
        do_op(6'b100000, 6'b111111, 1'b1);
    endtask

    task automatic test_abort();
        bit stray;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 6'd5; bus.b = 6'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
            errors++;
            $display("FAIL abort_clear got busy=%b done=%b sum=%b c=%b o=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL abort_quiet got done/busy activity want none");
        end
        do_op(6'd2, 6'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [W-1:0] es;
        logic         ec, eo;
        first = -1; second = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 6'd1; bus.b = 6'd1;
        @(posedge clk);
        #1 bus.a = 6'd2; bus.b = 6'd2;
        for (int k = 0; k < 30 && second < 0; k++) begin
            @(negedge clk);
            if (first >= 0 && k == first + 1) begin
                bus.start = 1'b0;
                checks++;
                if ({bus.done, bus.busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_reaccept got done=%b busy=%b want done=0 busy=1",
                             bus.done, bus.busy);
                end
            end
            if (bus.done === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    model(6'd1, 6'd1, es, ec, eo);
                end else begin
                    second = k;
                    model(6'd2, 6'd2, es, ec, eo);
                end
                checks++;
                if ({bus.sum, bus.cout, bus.ovf} !== {es, ec, eo}) begin
                    errors++;
                    $display("FAIL b2b_result got sum=%b c=%b o=%b want sum=%b c=%b o=%b",
                             bus.sum, bus.cout, bus.ovf, es, ec, eo);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (first < 0 || second < 0 || (second - first) !== int'(W) + 1) begin
            errors++;
            $display("FAIL b2b_spacing got first=%0d second=%0d want spacing %0d",
                     first, second, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
